// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its requesters.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int unsigned PORT_CPU  = 0;
  localparam int unsigned PORT_LOAD = 1;

  function automatic logic [63:0] byte_span(input int unsigned words);
    return 64'(words) * 64'd4;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-port request/response bus into the data-memory arbiter; port i owns slice i.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [2*ADDRESS_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0]    req_wdata;
  logic [1:0]                 req_we;
  logic [1:0]                 req_be;
  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-requester round-robin grant; the port that did not win last time wins a tie.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic       o_valid,
  output logic       o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx   = 1'b0;
    if (i_req == 2'b11) begin
      o_idx = ~i_rr_last;
    end else if (i_req[1]) begin
      o_idx = 1'b1;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data_memory between the CPU and loader ports: accept, one access cycle, registered response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_SIZE      = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  dmem_arbiter_if.slave            bus,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_we,
  output logic                     mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);
  localparam logic [ADDRESS_WIDTH:0] SPAN = (ADDRESS_WIDTH+1)'(byte_span(MEM_SIZE));

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_rr_last;
  logic                     r_owner;
  logic                     r_we;
  logic                     r_be;
  logic                     r_err;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;

  logic                     w_gvalid;
  logic                     w_gidx;
  logic                     w_accept;
  logic                     w_err;
  logic [1:0]               w_req_ready;
  logic [1:0]               w_rsp_valid;
  logic [DATA_WIDTH-1:0]    w_rsp_rdata;
  logic                     w_rsp_err;

  rr_arbiter2 u_arb (
    .i_req    (bus.req_valid),
    .i_rr_last(r_rr_last),
    .o_valid  (w_gvalid),
    .o_idx    (w_gidx)
  );

  assign w_err = ({1'b0, r_addr} >= SPAN) || (!r_be && (r_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner   <= w_gidx;
        r_rr_last <= w_gidx;
        r_addr    <= w_gidx ? bus.req_addr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                            : bus.req_addr[ADDRESS_WIDTH-1:0];
        r_wdata   <= w_gidx ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : bus.req_wdata[DATA_WIDTH-1:0];
        r_we      <= bus.req_we[w_gidx];
        r_be      <= bus.req_be[w_gidx];
      end
      // Response data is frozen here so it stays stable however long RESP is held.
      if (r_state == ACCESS) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? '0 : mem_read_data;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_req_ready    = '0;
    w_rsp_valid    = '0;
    w_rsp_rdata    = '0;
    w_rsp_err      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_we         = 1'b0;
    mem_be         = 1'b0;
    unique case (r_state)
      IDLE: begin
        // rst gates ready so nothing is offered while reset is asserted.
        if (rst && w_gvalid) begin
          w_req_ready[w_gidx] = 1'b1;
          w_accept            = 1'b1;
          w_next              = ACCESS;
        end
      end
      ACCESS: begin
        mem_address    = r_addr;
        mem_write_data = r_wdata;
        mem_we         = r_we & ~w_err;
        mem_be         = r_be;
        w_next         = RESP;
      end
      RESP: begin
        w_rsp_valid[r_owner] = 1'b1;
        w_rsp_rdata          = r_rdata;
        w_rsp_err            = r_err;
        if (bus.rsp_ready[r_owner]) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_rdata;
  assign bus.rsp_err   = w_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data_memory plus a byte-array reference model of expected responses.
module tb_dmem_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned MS    = 1024;
  localparam int unsigned SPANB = MS * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          mem_we;
  logic          mem_be;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_read_data (mem_read_data)
  );

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int cyc    = 0;

  function automatic logic [7:0] init_byte(input int unsigned i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // data_memory stand-in: combinational read, write on the rising edge.
  logic [7:0]  mem_bytes [SPANB];
  logic        mem_init_done = 1'b0;
  logic [31:0] w_base;
  assign w_base = {mem_address[31:2], 2'b00};

  always_comb begin
    mem_read_data = '0;
    if (mem_address < 32'(SPANB)) begin
      if (mem_be) mem_read_data = {24'b0, mem_bytes[mem_address[11:0]]};
      else        mem_read_data = {mem_bytes[w_base[11:0] + 12'd3], mem_bytes[w_base[11:0] + 12'd2],
                                   mem_bytes[w_base[11:0] + 12'd1], mem_bytes[w_base[11:0]]};
    end
  end

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < int'(SPANB); i++) mem_bytes[i] <= init_byte(i);
      mem_init_done <= 1'b1;
    end else if (mem_we === 1'b1 && mem_address < 32'(SPANB)) begin
      if (mem_be) mem_bytes[mem_address[11:0]] <= mem_write_data[7:0];
      else for (int k = 0; k < 4; k++) mem_bytes[{mem_address[11:2], 2'(k)}] <= mem_write_data[8*k +: 8];
    end
  end

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;
  always @(posedge clk) cyc++;

  // Reference model: what each request should return, from the access rules alone.
  logic [7:0] ref_bytes [SPANB];

  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic we, input logic be,
                       output logic [31:0] rd, output logic er);
    er = (a >= 32'(SPANB)) || (!be && a[1:0] != 2'b00);
    rd = '0;
    if (!er) begin
      if (we) begin
        if (be) ref_bytes[a] = d[7:0];
        else for (int k = 0; k < 4; k++) ref_bytes[a + 32'(k)] = d[8*k +: 8];
      end else begin
        rd = be ? {24'b0, ref_bytes[a]} : {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
      end
    end
  endtask

  task automatic xact(input int p, input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic be, output logic [31:0] rd, output logic er, output int lat,
                      output int acc_cyc);
    int n;
    rd = '0; er = 1'b0; lat = -1; acc_cyc = -1;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_wdata[p*DW +: DW] = d;
    bus.req_we[p]    = we;
    bus.req_be[p]    = be;
    bus.req_valid[p] = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[p] === 1'b1) break;
    end
    if (n == 50) begin
      bus.req_valid[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.req_valid[p] = 1'b0;
    for (n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (bus.rsp_valid[p] === 1'b1) begin
        lat = n; rd = bus.rsp_rdata; er = bus.rsp_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req_valid = '0; bus.req_we = '0; bus.req_be = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 2'b11; bus.req_we = 2'b11; bus.req_be = 2'b01;
    bus.req_addr = {32'h10, 32'h20}; bus.req_wdata = '1; bus.rsp_ready = 2'b11;
    #3;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0) begin
      errors++; $display("FAIL reset_rsp got=%b/%b/%h exp=00/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_be !== 1'b0 || mem_address !== '0 || mem_write_data !== '0) begin
      errors++; $display("FAIL reset_mem got=%b/%b/%h/%h exp=0/0/0/0", mem_we, mem_be, mem_address, mem_write_data);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd, erd; logic er, eer; int lat, acc, w0;
    w0 = we_cnt;
    model(32'h18, 32'hb6a84325, 1'b1, 1'b0, erd, eer);
    xact(0, 32'h18, 32'hb6a84325, 1'b1, 1'b0, rd, er, lat, acc);
    checks++;
    if (we_cnt - w0 != 1) begin errors++; $display("FAIL word_write_we_cycles got=%0d exp=1", we_cnt - w0); end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      errors++; $display("FAIL word_write_rsp got=err%b/%h/lat%0d exp=err0/0/lat2", er, rd, lat);
    end
    model(32'h18, 32'h0, 1'b0, 1'b0, erd, eer);
    xact(0, 32'h18, 32'h0, 1'b0, 1'b0, rd, er, lat, acc);
    checks++;
    if (rd !== 32'hb6a84325 || er !== 1'b0 || lat != 2) begin
      errors++; $display("FAIL word_read got=%h/err%b/lat%0d exp=b6a84325/err0/lat2", rd, er, lat);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, erd; logic er, eer; int lat, acc;
    model(32'h19, 32'hffffff74, 1'b1, 1'b1, erd, eer);
    xact(1, 32'h19, 32'hffffff74, 1'b1, 1'b1, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL byte_write_rsp got=err%b/%h exp=err0/0", er, rd); end
    model(32'h18, 32'h0, 1'b0, 1'b0, erd, eer);
    xact(0, 32'h18, 32'h0, 1'b0, 1'b0, rd, er, lat, acc);
    checks++;
    if (rd !== 32'hb6a87425 || er !== 1'b0) begin
      errors++; $display("FAIL byte_merge_read got=%h/err%b exp=b6a87425/err0", rd, er);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] addr [2];
    logic [31:0] expq [$];
    int          ownq [$];
    logic [31:0] rd, ed; logic er;
    int ng, nd, g, own;
    ng = 0; nd = 0;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      addr[p] = 32'($urandom_range(0, MS-1)) << 2;
      bus.req_addr[p*AW +: AW] = addr[p];
    end
    bus.req_we = '0; bus.req_be = '0; bus.req_valid = 2'b11;
    for (int c = 0; c < 80 && nd < 6; c++) begin
      g = -1;
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) begin
        checks++;
        if (ownq.size() == 0) begin
          errors++; $display("FAIL rr_spurious_rsp got=%b exp=00", bus.rsp_valid);
        end else begin
          own = ownq.pop_front(); ed = expq.pop_front();
          if (bus.rsp_valid !== (2'b01 << own) || bus.rsp_rdata !== ed) begin
            errors++; $display("FAIL rr_rsp got=%b/%h exp=%b/%h", bus.rsp_valid, bus.rsp_rdata, 2'b01 << own, ed);
          end
        end
        nd++;
      end
      if (bus.req_ready !== 2'b00) begin
        g = (bus.req_ready[1] === 1'b1) ? 1 : 0;
        checks++;
        if (bus.req_ready !== (2'b01 << g) || g != ng % 2) begin
          errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", ng, bus.req_ready, 2'b01 << (ng % 2));
        end
        model(addr[g], 32'h0, 1'b0, 1'b0, rd, er);
        expq.push_back(rd); ownq.push_back(g);
        ng++;
      end
      @(posedge clk); #1;
      if (g >= 0) begin
        if (ng >= 6) bus.req_valid = '0;
        else begin
          addr[g] = 32'($urandom_range(0, MS-1)) << 2;
          bus.req_addr[g*AW +: AW] = addr[g];
        end
      end
    end
    bus.req_valid = '0;
    checks++;
    if (ng != 6 || nd != 6) begin errors++; $display("FAIL rr_count got=%0d/%0d exp=6/6", ng, nd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat, acc, w0;
    w0 = we_cnt;
    model(32'h1a, 32'h0, 1'b0, 1'b0, erd, eer);
    xact(0, 32'h1a, 32'h0, 1'b0, 1'b0, rd, er, lat, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_read got=err%b/%h exp=err1/0", er, rd); end
    model(32'h1000, 32'h12345678, 1'b1, 1'b0, erd, eer);
    xact(1, 32'h1000, 32'h12345678, 1'b1, 1'b0, rd, er, lat, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_write got=err%b/%h exp=err1/0", er, rd); end
    xact(0, 32'h1000, 32'h0, 1'b0, 1'b1, rd, er, lat, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_byte_read got=err%b/%h exp=err1/0", er, rd); end
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL err_mem_we got=%0d exp=0", we_cnt - w0); end
    model(32'hffc, 32'h0, 1'b0, 1'b0, erd, eer);
    xact(0, 32'hffc, 32'h0, 1'b0, 1'b0, rd, er, lat, acc);
    checks++;
    if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL last_word_read got=%h/err%b exp=%h/err0", rd, er, erd); end
    model(32'hfff, 32'h5a, 1'b1, 1'b1, erd, eer);
    xact(1, 32'hfff, 32'h5a, 1'b1, 1'b1, rd, er, lat, acc);
    model(32'hfff, 32'h0, 1'b0, 1'b1, erd, eer);
    xact(0, 32'hfff, 32'h0, 1'b0, 1'b1, rd, er, lat, acc);
    checks++;
    if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL last_byte_rw got=%h/err%b exp=%h/err0", rd, er, erd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e0, e1, rd; logic er; int n;
    model(32'h40, 32'h0, 1'b0, 1'b0, e0, er);
    model(32'h44, 32'h0, 1'b0, 1'b0, e1, er);
    bus.rsp_ready = 2'b10;
    bus.req_addr = {32'h44, 32'h40}; bus.req_we = '0; bus.req_be = '0;
    bus.req_valid = 2'b01;
    for (n = 0; n < 20; n++) begin @(negedge clk); if (bus.req_ready[0] === 1'b1) break; end
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    for (n = 0; n < 20; n++) begin @(negedge clk); if (bus.rsp_valid[0] === 1'b1) break; end
    checks++;
    if (n == 20) begin errors++; $display("FAIL bp_rsp_timeout got=none exp=rsp_valid[0]"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== e0 || bus.rsp_err !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got=%b/%h/%b exp=01/%h/0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e0);
      end
      checks++;
      if (bus.req_ready !== 2'b00 || mem_we !== 1'b0 || mem_address !== '0) begin
        errors++; $display("FAIL bp_idle_%0d got=%b/%b/%h exp=00/0/0", i, bus.req_ready, mem_we, mem_address);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready got=%b exp=10", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    for (n = 0; n < 20; n++) begin @(negedge clk); if (bus.rsp_valid[1] === 1'b1) break; end
    rd = bus.rsp_rdata;
    checks++;
    if (n == 20 || rd !== e1) begin errors++; $display("FAIL bp_port1_read got=%h exp=%h", rd, e1); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, a; logic er, eer; int lat, acc, prev;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(0, MS-1)) << 2;
      model(a, 32'h0, 1'b0, 1'b0, erd, eer);
      xact(1, a, 32'h0, 1'b0, 1'b0, rd, er, lat, acc);
      checks++;
      if (rd !== erd || (prev >= 0 && acc - prev != 3)) begin
        errors++; $display("FAIL b2b_%0d got=%h/gap%0d exp=%h/gap3", i, rd, acc - prev, erd);
      end
      prev = acc;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, we, be; int lat, acc, p;
    for (int i = 0; i < 30; i++) begin
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      be = 1'($urandom_range(0, 1));
      d  = $urandom;
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(SPANB, SPANB + 64)) : 32'($urandom_range(0, SPANB - 1));
      model(a, d, we, be, erd, eer);
      xact(p, a, d, we, be, rd, er, lat, acc);
      checks++;
      if (rd !== erd || er !== eer || lat != 2) begin
        errors++; $display("FAIL rand_%0d p%0d a=%h we%b be%b got=%h/err%b/lat%0d exp=%h/err%b/lat2",
                           i, p, a, we, be, rd, er, lat, erd, eer);
      end
    end
  endtask

  task automatic test_reset_access();
    logic [31:0] rd, erd; logic er, eer; int lat, acc, n, w0;
    bus.req_addr[AW-1:0] = 32'h20; bus.req_wdata[DW-1:0] = 32'hdeadbeef;
    bus.req_we[0] = 1'b1; bus.req_be[0] = 1'b0; bus.req_valid[0] = 1'b1;
    for (n = 0; n < 20; n++) begin @(negedge clk); if (bus.req_ready[0] === 1'b1) break; end
    @(posedge clk); #1;
    bus.req_valid = '0;
    #2;
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 32'h20) begin
      errors++; $display("FAIL rst_pre_access got=%b/%h exp=1/00000020", mem_we, mem_address);
    end
    w0 = we_cnt;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_address !== '0 || mem_write_data !== '0 || mem_be !== 1'b0 ||
        bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL rst_async_outputs got=%b/%h/%h/%b exp=0/0/0/00", mem_we, mem_address, mem_write_data, bus.rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_lost_rsp_%0d got=%b exp=00", i, bus.rsp_valid); end
    end
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL rst_write_commit got=%0d exp=0", we_cnt - w0); end
    @(posedge clk); #1;
    model(32'h20, 32'h0, 1'b0, 1'b0, erd, eer);
    xact(0, 32'h20, 32'h0, 1'b0, 1'b0, rd, er, lat, acc);
    checks++;
    if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL rst_old_value got=%h exp=%h", rd, erd); end
  endtask

  initial begin
    for (int i = 0; i < int'(SPANB); i++) ref_bytes[i] = init_byte(i);
    test_reset();
    do_reset();
    test_word_rw();
    test_byte_write();
    test_fairness();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data_memory between two requesters: port 0 (CPU load/store unit) and port 1 (loader/DMA engine that fills or dumps memory).
- Accepts one request at a time over a valid/ready handshake and arbitrates round-robin.
- Drives data_memory's address/write_data/we/be for exactly one cycle per access, then returns a registered response with error flagging.
- Sits between the core/loader and data_memory in the Unicycle top level.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDRESS_WIDTH, 32, byte address width.
- MEM_SIZE, 1024, memory depth in DATA_WIDTH words; byte span = MEM_SIZE*4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid  input  2  per-port request valid (bit i = port i).
- req_ready  output  2  per-port request accept.
- req_addr  input  2*ADDRESS_WIDTH  per-port byte address; port i occupies slice i.
- req_wdata  input  2*DATA_WIDTH  per-port write data.
- req_we  input  2  per-port write enable.
- req_be  input  2  per-port byte-access select (1 = byte, 0 = word).
- rsp_valid  output  2  per-port response valid.
- rsp_ready  input  2  per-port response accept.
- rsp_rdata  output  DATA_WIDTH  read data of the current response; 0 for writes and errors.
- rsp_err  output  1  current response is an error.
- mem_address  output  ADDRESS_WIDTH  to data_memory address.
- mem_write_data  output  DATA_WIDTH  to data_memory write_data.
- mem_we  output  1  to data_memory we.
- mem_be  output  1  to data_memory be.
- mem_read_data  input  DATA_WIDTH  from data_memory read_data; combinational read.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_last=1, so port 0 wins the first tie.
  - All outputs 0; latched request cleared.
- FSM:
  - IDLE -> ACCESS on accept.
  - ACCESS -> RESP unconditionally after 1 cycle.
  - RESP -> IDLE when rsp_ready[owner]=1.
- IDLE:
  - Grant goes to the only valid port. If both ports are valid, grant the port != rr_last.
  - req_ready[grant]=1 combinationally, only in IDLE; the other bit stays 0.
  - On handshake, latch addr/wdata/we/be/owner and set rr_last=owner.
- ACCESS:
  - mem_address/mem_write_data/mem_be come from the latched request.
  - mem_we = latched_we & ~err; this is the only cycle mem_we can be 1.
  - mem_read_data is captured into the rdata register at the ACCESS->RESP edge; a write commits at that same edge.
  - err is set when either condition holds:
    - addr >= MEM_SIZE*4;
    - word access (be=0) with addr[1:0] != 0.
  - Byte accesses may use any in-range address.
- RESP:
  - rsp_valid[owner]=1 and held until rsp_ready[owner]=1.
  - rsp_rdata is stable while held: captured data for an error-free read, 0 for writes and errors. rsp_err=latched err.
- Outside ACCESS: mem_* outputs = 0.
- Timing:
  - Minimum 3 cycles per access (accept, access, response) when rsp_ready is held 1.
  - Accept-to-rsp_valid latency = 2 cycles.
- Requests arriving while not in IDLE see req_ready=0 and must hold; no queueing.
- Fairness:
  - Continuous requests from both ports alternate 0,1,0,1.
  - A lone port is granted back-to-back with no bubble beyond the FSM cycles.
- Reset during ACCESS: mem_we drops immediately, the write is not committed and the response is lost; the requester reissues.
- Reset during RESP: the response is discarded.

Decomposition:
- Package dmem_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - port index constants PORT_CPU=0, PORT_LOAD=1;
  - localparam function for byte span (MEM_SIZE*4).
- One sub-module, rr_arbiter2: a two-request round-robin grant with rr_last input; purely combinational, reused by future peripheral buses.
- Top module: FSM, request latch and response register.

Test Plan:
- Port 0 word write addr 0x18 data 0xb6a84325, then read 0x18:
  - write: mem_we=1 for exactly 1 cycle, rsp_err=0, rsp_rdata=0;
  - read: rsp_rdata=0xb6a84325.
- Port 1 byte write addr 0x19 data 0x74 (be=1), then port 0 word read 0x18 -> rsp_rdata=0xb6a87425, both rsp_err=0.
- Both ports valid continuously for 6 accesses after reset -> grant order 0,1,0,1,0,1; each rsp_valid goes to the granted port only.
- Word read at 0x1A and word write at 0x1000 (MEM_SIZE=1024):
  - both give rsp_err=1, rsp_rdata=0;
  - mem_we never asserts;
  - a subsequent read of 0xFFC returns its prior contents.
- rsp_ready[0] held 0 for 5 cycles during RESP:
  - rsp_valid/rsp_rdata stay stable;
  - port 1 req_ready stays 0 until the response is taken.
- rst pulled low during ACCESS of a write to 0x20 = 0xdeadbeef:
  - all outputs go to 0 asynchronously;
  - after release, a read of 0x20 returns the old value.
